// File: rtl/serial_adder_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package serial_adder_ctrl_pkg;

  // Controller states. The encodings are fixed because other blocks decode them.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Width of the bit counter. It must be able to reach WIDTH-1.
  function automatic int cnt_w(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// 1-bit full adder built from two half adders and an OR gate.
// Latency: purely combinational, 0 cycles.
// Backpressure: none.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic s0;
  logic c0;
  logic c1;

  half_adder u_ha0 (.a(a),  .b(b),   .s(s0),  .c(c0));
  half_adder u_ha1 (.a(s0), .b(cin), .s(sum), .c(c1));

  // The two half-adder carries can never both be set, so OR gives the majority.
  assign cout = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder (A-B when SERIAL_SUB_EN is defined), one bit per clock, LSB first.
// Latency: start accepted at edge k -> done pulses in the cycle after edge k+WIDTH.
// Backpressure: start is only accepted in IDLE/DONE; start while busy is ignored.
module serial_adder_ctrl
  import serial_adder_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out
);

  localparam int CNT_W = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_nxt;
  logic             load;
  logic             step;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic             carry;
  logic             b_bit;
  logic             carry_init;
  logic             cell_sum;
  logic             cell_cout;

`ifdef SERIAL_SUB_EN
  logic sub_q;

  // Subtraction is A + ~B + 1: invert B into the cell and seed the carry with 1.
  assign b_bit      = sh_b[0] ^ sub_q;
  assign carry_init = sub;
`else
  assign b_bit      = sh_b[0];
  assign carry_init = 1'b0;
`endif

  assign last = (cnt == CNT_LAST);

  fa_cell u_fa (
    .a    (sh_a[0]),
    .b    (b_bit),
    .cin  (carry),
    .sum  (cell_sum),
    .cout (cell_cout)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode plus handshake outputs and datapath strobes.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_ADD;
        end
      end
      ST_ADD: begin
        busy = 1'b1;
        step = 1'b1;
        if (last) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_ADD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, serial shifting, and result/carry registers; result only moves in ADD.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      sh_a      <= '0;
      sh_b      <= '0;
      carry     <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q     <= 1'b0;
`endif
    end else if (load) begin
      sh_a  <= op_a;
      sh_b  <= op_b;
      carry <= carry_init;
      cnt   <= '0;
`ifdef SERIAL_SUB_EN
      sub_q <= sub;
`endif
    end else if (step) begin
      sh_a   <= sh_a >> 1;
      sh_b   <= sh_b >> 1;
      carry  <= cell_cout;
      result <= {cell_sum, result[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      if (last) carry_out <= cell_cout;
    end
  end

endmodule
